program_counter_ctrl: RTL and testbench
=======================================

Name: program_counter_ctrl

Overview:
- Parametrised next-generation instruction program counter for the lab CPU.
- Provides the following, driving the instruction-memory address directly from a register:
  - sequential increment with wrap;
  - absolute jump;
  - signed relative branch;
  - call/return through an internal return-address stack;
  - stall and halt/resume.

Parameters:
- ADDR_BITS, 5: width of the instruction address.
- OFFSET_BITS, 4: width of the signed two's-complement branch offset. Must be <= ADDR_BITS.
- STACK_DEPTH, 4: number of return-address stack entries. Must be >= 1.
- RESET_ADDR, 0: value loaded into the PC on reset.

Ports:
- clk, input, 1: clock. All state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- stall, input, 1: freeze all state this cycle.
- halt_req, input, 1: enter HALT.
- resume, input, 1: leave HALT.
- jump_en, input, 1: absolute jump to jump_addr.
- jump_addr, input, ADDR_BITS: jump/call target.
- branch_en, input, 1: relative branch.
- branch_offset, input, OFFSET_BITS: signed offset added to the current PC.
- call_en, input, 1: push return address, then go to jump_addr.
- ret_en, input, 1: pop the return address into the PC.
- instruction_address, output, ADDR_BITS: current PC (register output).
- halted, output, 1: high while in HALT.
- stack_count, output, $clog2(STACK_DEPTH+1): number of valid stack entries.
- stack_err, output, 1: sticky overflow/underflow flag.

Behaviour:
- Reset:
  - Applies when rst=1 at a clock edge and overrides every other input.
  - Loads instruction_address=RESET_ADDR, halted=0, stack_count=0, stack_err=0, state=RUN.
  - Stack contents need not be cleared.
  - Reset asserted mid-call/mid-halt discards all pending state.
- State machine: two states, RUN and HALT.
- Priority in RUN (evaluated each edge, highest first; exactly one action per cycle):
  1. stall=1: PC, stack, state all hold. Every other input is ignored and dropped, not queued.
  2. halt_req=1: go to HALT; PC holds.
  3. ret_en=1:
     - If stack_count>0: PC<=top entry; stack_count decrements.
     - Else (underflow): PC<=PC+1, stack_err<=1, stack_count stays 0.
  4. call_en=1:
     - If stack_count<STACK_DEPTH: push (PC+1) mod 2^ADDR_BITS, stack_count increments, PC<=jump_addr.
     - Else (overflow): no push, stack_count holds, stack_err<=1, PC<=jump_addr anyway.
  5. jump_en=1: PC<=jump_addr.
  6. branch_en=1: PC<=(PC + sign_extend(branch_offset)) mod 2^ADDR_BITS.
  7. Otherwise: PC<=(PC+1) mod 2^ADDR_BITS. The all-ones address wraps to 0.
- HALT state:
  - PC and stack hold; halted=1.
  - jump/branch/call/ret/halt_req are ignored.
  - resume=1 with stall=0 returns to RUN. PC is unchanged on that edge; incrementing restarts the following cycle.
  - stall=1 in HALT blocks resume.
- Simultaneous events: resolved strictly by the priority list above. For example, call_en+ret_en together performs the ret only.
- Stack:
  - LIFO, STACK_DEPTH entries of ADDR_BITS each.
  - Entries are addressed by stack_count (push writes index stack_count, pop reads index stack_count-1).
- Error flag: stack_err is sticky and is cleared only by rst.
- Latency: every action updates instruction_address on the edge where it is sampled. There is no combinational path from any input to instruction_address.
- Output timing: halted and stack_count are registered state, valid the cycle after the causing edge.

Test Plan:
1. Reset then free-run, defaults: rst=1 for 2 cycles, then 0 for 34 cycles -> address 0,1,...,31,0,1 (wraps after 31); halted=0; stack_err=0.
2. Jump and branch:
   - PC=10, jump_en with jump_addr=3 -> next PC=3.
   - Then branch_en with offset=4'b1110 (-2) -> PC=1.
   - Then branch_en with offset=-2 -> PC=31 (wrap below 0).
3. Call/return nesting:
   - PC=5, call to 20 -> PC=20, stack_count=1.
   - At PC=21, call to 8 -> PC=8, stack_count=2.
   - ret -> PC=22; ret -> PC=6; stack_count=0; stack_err=0.
4. Stack error:
   - 5 consecutive calls with STACK_DEPTH=4 -> 5th still jumps, stack_count=4, stack_err=1.
   - After draining with 4 rets, a 5th ret at PC=p -> PC=p+1, stack_count=0.
   - stack_err stays 1 until rst.
5. Stall/halt priority:
   - stall=1 together with jump_en for 3 cycles -> PC unchanged; the jump is lost.
   - halt_req at PC=7 -> halted=1, PC stays 7 despite jump_en.
   - resume -> RUN with PC=7, then 8 the next cycle.
   - resume together with stall -> remains halted.
6. Reset mid-operation: stack_count=3, halted=1, stack_err=1, then assert rst one cycle -> PC=RESET_ADDR, halted=0, stack_count=0, stack_err=0. Repeat with RESET_ADDR=16 -> PC=16.

Source files
------------

// File: rtl/program_counter_ctrl.sv
// Instruction program counter: sequential fetch with wrap, absolute jump,
// signed relative branch, call/return via a return-address stack, stall,
// and halt/resume. The PC register drives the instruction address directly.
module program_counter_ctrl #(
   parameter int unsigned ADDR_BITS   = 5,
   parameter int unsigned OFFSET_BITS = 4,
   parameter int unsigned STACK_DEPTH = 4,
   parameter int unsigned RESET_ADDR  = 0
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 stall,
   input  logic                                 halt_req,
   input  logic                                 resume,
   input  logic                                 jump_en,
   input  logic [ADDR_BITS-1:0]                 jump_addr,
   input  logic                                 branch_en,
   input  logic [OFFSET_BITS-1:0]               branch_offset,
   input  logic                                 call_en,
   input  logic                                 ret_en,
   output logic [ADDR_BITS-1:0]                 instruction_address,
   output logic                                 halted,
   output logic [$clog2(STACK_DEPTH+1)-1:0]     stack_count,
   output logic                                 stack_err
);

   localparam int unsigned CountBits = $clog2(STACK_DEPTH + 1);
   localparam int unsigned IdxBits   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   // Elaboration-time sanity checks on the parameter set.
   if (OFFSET_BITS > ADDR_BITS) begin : gen_offset_check
      $error("OFFSET_BITS must not exceed ADDR_BITS");
   end
   if (STACK_DEPTH < 1) begin : gen_depth_check
      $error("STACK_DEPTH must be at least 1");
   end

   typedef enum logic [0:0] {StRun = 1'b0, StHalt = 1'b1} state_e;

   state_e               state_q;
   logic [ADDR_BITS-1:0] pc_q;
   logic [CountBits-1:0] count_q;
   logic                 err_q;
   logic [ADDR_BITS-1:0] stack_q [STACK_DEPTH];

   logic [ADDR_BITS-1:0] pc_inc;
   logic [ADDR_BITS-1:0] branch_target;
   logic [IdxBits-1:0]   push_idx;
   logic [IdxBits-1:0]   pop_idx;
   logic                 stack_full;
   logic                 stack_empty;
   logic                 do_push;

   // Address arithmetic, stack indexing and the push strobe.
   always_comb begin
      pc_inc        = pc_q + ADDR_BITS'(1);
      // Size cast of a signed operand sign-extends the offset.
      branch_target = pc_q + ADDR_BITS'($signed(branch_offset));
      stack_full    = (count_q == CountBits'(STACK_DEPTH));
      stack_empty   = (count_q == '0);
      push_idx      = IdxBits'(count_q);
      pop_idx       = IdxBits'(count_q - CountBits'(1));
      // A push happens only when call wins priority in RUN and there is room.
      do_push       = !rst && !stall && (state_q == StRun) && !halt_req && !ret_en &&
                      call_en && !stack_full;
   end

   // Return-address storage; contents are not reset.
   always_ff @(posedge clk) begin
      if (do_push) begin
         stack_q[push_idx] <= pc_inc;
      end
   end

   // RUN/HALT state machine with PC, stack depth and sticky error registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StRun;
         pc_q    <= ADDR_BITS'(RESET_ADDR);
         count_q <= '0;
         err_q   <= 1'b0;
      end else if (!stall) begin
         case (state_q)
            StRun: begin
               if (halt_req) begin
                  state_q <= StHalt;
               end else if (ret_en) begin
                  if (!stack_empty) begin
                     pc_q    <= stack_q[pop_idx];
                     count_q <= count_q - CountBits'(1);
                  end else begin
                     pc_q  <= pc_inc;
                     err_q <= 1'b1;
                  end
               end else if (call_en) begin
                  // Overflowing call still transfers control, it just loses the link.
                  pc_q <= jump_addr;
                  if (!stack_full) begin
                     count_q <= count_q + CountBits'(1);
                  end else begin
                     err_q <= 1'b1;
                  end
               end else if (jump_en) begin
                  pc_q <= jump_addr;
               end else if (branch_en) begin
                  pc_q <= branch_target;
               end else begin
                  pc_q <= pc_inc;
               end
            end
            StHalt: begin
               if (resume) begin
                  state_q <= StRun;
               end
            end
            default: begin
               state_q <= StRun;
            end
         endcase
      end
   end

   assign instruction_address = pc_q;
   assign halted              = (state_q == StHalt);
   assign stack_count         = count_q;
   assign stack_err           = err_q;

endmodule

// File: tb/tb_program_counter_ctrl.sv
// Self-checking bench for program_counter_ctrl. Two instances share stimulus,
// one with the default reset address and one with RESET_ADDR=16. A behavioural
// model tracks both and is compared every cycle; directed literal checks pin
// the expected trajectory.
module tb_program_counter_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       stall;
   logic       halt_req;
   logic       resume;
   logic       jump_en;
   logic [4:0] jump_addr;
   logic       branch_en;
   logic [3:0] branch_offset;
   logic       call_en;
   logic       ret_en;

   logic [4:0] pc0, pc1;
   logic       halted0, halted1;
   logic [2:0] cnt0, cnt1;
   logic       err0, err1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   program_counter_ctrl dut0 (
      .clk                 (clk),
      .rst                 (rst),
      .stall               (stall),
      .halt_req            (halt_req),
      .resume              (resume),
      .jump_en             (jump_en),
      .jump_addr           (jump_addr),
      .branch_en           (branch_en),
      .branch_offset       (branch_offset),
      .call_en             (call_en),
      .ret_en              (ret_en),
      .instruction_address (pc0),
      .halted              (halted0),
      .stack_count         (cnt0),
      .stack_err           (err0)
   );

   program_counter_ctrl #(.RESET_ADDR(16)) dut16 (
      .clk                 (clk),
      .rst                 (rst),
      .stall               (stall),
      .halt_req            (halt_req),
      .resume              (resume),
      .jump_en             (jump_en),
      .jump_addr           (jump_addr),
      .branch_en           (branch_en),
      .branch_offset       (branch_offset),
      .call_en             (call_en),
      .ret_en              (ret_en),
      .instruction_address (pc1),
      .halted              (halted1),
      .stack_count         (cnt1),
      .stack_err           (err1)
   );

   task automatic cmp(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_pc   [2];
   int m_cnt  [2];
   int m_stk  [2][4];
   bit m_halt [2];
   bit m_err  [2];
   bit m_valid = 1'b0;

   // Inputs change 1 time unit after each negedge, so at the negedge they
   // still hold the values sampled by the preceding posedge.
   initial begin
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            int off;
            off = int'(branch_offset);
            if (off >= 8) off -= 16;
            if (rst) begin
               m_pc[k]   = (k == 0) ? 0 : 16;
               m_cnt[k]  = 0;
               m_halt[k] = 1'b0;
               m_err[k]  = 1'b0;
            end else if (stall) begin
               // everything holds
            end else if (m_halt[k]) begin
               if (resume) m_halt[k] = 1'b0;
            end else if (halt_req) begin
               m_halt[k] = 1'b1;
            end else if (ret_en) begin
               if (m_cnt[k] > 0) begin
                  m_cnt[k]--;
                  m_pc[k] = m_stk[k][m_cnt[k]];
               end else begin
                  m_pc[k]  = (m_pc[k] + 1) % 32;
                  m_err[k] = 1'b1;
               end
            end else if (call_en) begin
               if (m_cnt[k] < 4) begin
                  m_stk[k][m_cnt[k]] = (m_pc[k] + 1) % 32;
                  m_cnt[k]++;
               end else begin
                  m_err[k] = 1'b1;
               end
               m_pc[k] = int'(jump_addr);
            end else if (jump_en) begin
               m_pc[k] = int'(jump_addr);
            end else if (branch_en) begin
               m_pc[k] = (m_pc[k] + off + 32) % 32;
            end else begin
               m_pc[k] = (m_pc[k] + 1) % 32;
            end
         end
         if (rst) m_valid = 1'b1;
         if (m_valid) begin
            cmp("model_pc0",     int'(pc0),     m_pc[0]);
            cmp("model_halted0", int'(halted0), int'(m_halt[0]));
            cmp("model_count0",  int'(cnt0),    m_cnt[0]);
            cmp("model_err0",    int'(err0),    int'(m_err[0]));
            cmp("model_pc16",    int'(pc1),     m_pc[1]);
            cmp("model_halted16", int'(halted1), int'(m_halt[1]));
            cmp("model_count16", int'(cnt1),    m_cnt[1]);
            cmp("model_err16",   int'(err1),    int'(m_err[1]));
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic clr();
      rst           = 1'b0;
      stall         = 1'b0;
      halt_req      = 1'b0;
      resume        = 1'b0;
      jump_en       = 1'b0;
      jump_addr     = 5'd0;
      branch_en     = 1'b0;
      branch_offset = 4'd0;
      call_en       = 1'b0;
      ret_en        = 1'b0;
   endtask

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         #1;
      end
   endtask

   initial begin
      clr();
      rst = 1'b1;
      // 1. reset then free-run with wrap
      step(2);
      cmp("reset_pc", int'(pc0), 0);
      cmp("reset_pc16", int'(pc1), 16);
      cmp("reset_halted", int'(halted0), 0);
      cmp("reset_count", int'(cnt0), 0);
      cmp("reset_err", int'(err0), 0);
      rst = 1'b0;
      for (int i = 1; i <= 33; i++) begin
         step();
         cmp("freerun_pc", int'(pc0), i % 32);
      end
      cmp("freerun_err", int'(err0), 0);

      // 2. jump and branch (pc now 1, advance to 10)
      step(9);
      cmp("pre_jump_pc", int'(pc0), 10);
      jump_en = 1'b1; jump_addr = 5'd3;
      step();
      cmp("jump_pc", int'(pc0), 3);
      clr();
      branch_en = 1'b1; branch_offset = 4'b1110;
      step();
      cmp("branch_back_pc", int'(pc0), 1);
      step();
      cmp("branch_wrap_pc", int'(pc0), 31);
      clr();

      // 3. call/return nesting
      step(6);
      cmp("pre_call_pc", int'(pc0), 5);
      call_en = 1'b1; jump_addr = 5'd20;
      step();
      cmp("call1_pc", int'(pc0), 20);
      cmp("call1_count", int'(cnt0), 1);
      clr();
      step();
      cmp("body_pc", int'(pc0), 21);
      call_en = 1'b1; jump_addr = 5'd8;
      step();
      cmp("call2_pc", int'(pc0), 8);
      cmp("call2_count", int'(cnt0), 2);
      clr();
      ret_en = 1'b1;
      step();
      cmp("ret1_pc", int'(pc0), 22);
      step();
      cmp("ret2_pc", int'(pc0), 6);
      cmp("ret2_count", int'(cnt0), 0);
      cmp("ret2_err", int'(err0), 0);
      clr();

      // 4. overflow then underflow
      for (int i = 0; i < 5; i++) begin
         call_en = 1'b1; jump_addr = 5'(10 + i);
         step();
         cmp("ovf_call_pc", int'(pc0), 10 + i);
      end
      cmp("ovf_count", int'(cnt0), 4);
      cmp("ovf_err", int'(err0), 1);
      clr();
      ret_en = 1'b1;
      step(4);
      cmp("drain_pc", int'(pc0), 7);
      cmp("drain_count", int'(cnt0), 0);
      step();
      cmp("udf_pc", int'(pc0), 8);
      cmp("udf_count", int'(cnt0), 0);
      cmp("udf_err", int'(err0), 1);
      clr();

      // 5. stall and halt priority
      stall = 1'b1; jump_en = 1'b1; jump_addr = 5'd0;
      step(3);
      cmp("stall_pc", int'(pc0), 8);
      clr();
      step();
      cmp("after_stall_pc", int'(pc0), 9);
      step(30);
      cmp("pre_halt_pc", int'(pc0), 7);
      halt_req = 1'b1; jump_en = 1'b1; jump_addr = 5'd3;
      step();
      cmp("halt_halted", int'(halted0), 1);
      cmp("halt_pc", int'(pc0), 7);
      clr();
      jump_en = 1'b1; jump_addr = 5'd3;
      step();
      cmp("halt_hold_pc", int'(pc0), 7);
      clr();
      resume = 1'b1; stall = 1'b1;
      step();
      cmp("stall_resume_halted", int'(halted0), 1);
      stall = 1'b0;
      step();
      cmp("resume_halted", int'(halted0), 0);
      cmp("resume_pc", int'(pc0), 7);
      clr();
      step();
      cmp("resume_next_pc", int'(pc0), 8);
      cmp("sticky_err", int'(err0), 1);

      // 6. reset mid-operation
      for (int i = 0; i < 3; i++) begin
         call_en = 1'b1; jump_addr = 5'(20 + i);
         step();
      end
      clr();
      halt_req = 1'b1;
      step();
      cmp("pre_rst_count", int'(cnt0), 3);
      cmp("pre_rst_halted", int'(halted0), 1);
      cmp("pre_rst_err", int'(err0), 1);
      clr();
      rst = 1'b1;
      step();
      cmp("mid_rst_pc", int'(pc0), 0);
      cmp("mid_rst_halted", int'(halted0), 0);
      cmp("mid_rst_count", int'(cnt0), 0);
      cmp("mid_rst_err", int'(err0), 0);
      cmp("mid_rst_pc16", int'(pc1), 16);
      rst = 1'b0;
      step();
      cmp("post_rst_pc", int'(pc0), 1);
      cmp("post_rst_pc16", int'(pc1), 17);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
